// File: rtl/simd_pkg.sv
// simd_pkg: shared lane geometry and collector state encoding
package simd_pkg;
  localparam int LANE_W = 32;
  localparam int NUM_LANES = 4;
  localparam int WORD_W = 2 * NUM_LANES * LANE_W;
  typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_DRAIN} state_t;
endpackage

// File: rtl/simd_result_fifo.sv
// simd_result_fifo: first-word-fall-through FIFO; holds the last popped word while empty
module simd_result_fifo #(
  parameter int DEPTH = 4,
  parameter int W = simd_pkg::WORD_W,
  parameter int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [W-1:0] last;
  logic do_push, do_pop;
  assign empty = level == '0;
  assign full = level == LW'(DEPTH);
  assign do_pop = pop & ~empty;
  // a full FIFO still takes a push when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);
  assign dout = empty ? last : mem[rd_ptr];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level <= '0;
      last <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_pop) last <= mem[rd_ptr];
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/simd_result_collector.sv
// simd_result_collector: packs per-processor result lanes into 256-bit words and streams a burst to the memory controller
module simd_result_collector #(
  parameter int FIFO_DEPTH = 4,
  parameter int LANE_W = 32,
  parameter int CNT_W = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_W-1:0]      data_size,
  input  logic                  result_valid,
  input  logic [LANE_W-1:0]     out_procc0,
  input  logic [LANE_W-1:0]     out_procc1,
  input  logic [LANE_W-1:0]     out_procc2,
  input  logic [LANE_W-1:0]     out_procc3,
  input  logic [LANE_W-1:0]     out_extra_procc0,
  input  logic [LANE_W-1:0]     out_extra_procc1,
  input  logic [LANE_W-1:0]     out_extra_procc2,
  input  logic [LANE_W-1:0]     out_extra_procc3,
  input  logic                  mc_ready_in,
  output logic                  mc_valid_out,
  output logic [4*LANE_W-1:0]   mc_data_out_lo,
  output logic [4*LANE_W-1:0]   mc_data_out_hi,
  output logic                  busy,
  output logic                  burst_done,
  output logic                  overflow,
  output logic [CNT_W-1:0]      fill_level
);
  import simd_pkg::*;
  localparam int PW = 2 * NUM_LANES * LANE_W;
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  state_t state, state_nxt;
  logic [CNT_W-1:0] exp_cnt, rcv_cnt;
  logic full, empty, push, pop, last_set;
  logic [LW-1:0] level;
  logic [PW-1:0] din, dout;
  assign din = {out_extra_procc3, out_extra_procc2, out_extra_procc1, out_extra_procc0,
                out_procc3, out_procc2, out_procc1, out_procc0};
  assign push = state == ST_COLLECT && result_valid;
  assign pop = !empty && mc_ready_in && state != ST_IDLE;
  assign last_set = rcv_cnt + 1'b1 == exp_cnt;
  simd_result_fifo #(.DEPTH(FIFO_DEPTH), .W(PW), .LW(LW)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(din),
    .dout(dout),
    .full(full),
    .empty(empty),
    .level(level)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= ST_IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start) state_nxt = data_size == '0 ? ST_DRAIN : ST_COLLECT;
      ST_COLLECT: if (result_valid && last_set) state_nxt = ST_DRAIN;
      ST_DRAIN:   if (empty) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end
  // every strobe counts toward the burst, including sets dropped on a full buffer
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      exp_cnt <= '0;
      rcv_cnt <= '0;
      overflow <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      exp_cnt <= data_size;
      rcv_cnt <= '0;
      overflow <= 1'b0;
    end else if (push) begin
      rcv_cnt <= rcv_cnt + 1'b1;
      if (full && !pop) overflow <= 1'b1;
    end
  always_comb begin
    busy = state != ST_IDLE;
    burst_done = state == ST_DRAIN && empty;
    mc_valid_out = !empty;
    mc_data_out_lo = dout[PW/2-1:0];
    mc_data_out_hi = dout[PW-1:PW/2];
    fill_level = CNT_W'(level);
  end
endmodule

// File: tb/tb_simd_result_collector.sv
// tb_simd_result_collector: table-driven result sets with a scoreboard on the memory-controller side
module tb_simd_result_collector;
  localparam int CW = 6;
  logic clk = 0, reset = 1, start = 0, result_valid = 0, mc_ready_in = 0;
  logic [CW-1:0] data_size = '0;
  logic [31:0] p0 = 0, p1 = 0, p2 = 0, p3 = 0, e0 = 0, e1 = 0, e2 = 0, e3 = 0;
  logic mc_valid_out, busy, burst_done, overflow;
  logic [127:0] lo, hi;
  logic [CW-1:0] fill_level;
  int errors = 0, checks = 0, pops = 0;

  typedef struct {
    logic [31:0] p0, p1, p2, p3, e0, e1, e2, e3;
    logic [127:0] lo, hi;
  } vec_t;
  vec_t tbl [6];
  logic [255:0] exp_q [$];

  simd_result_collector #(.FIFO_DEPTH(4), .LANE_W(32), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .data_size(data_size),
    .result_valid(result_valid),
    .out_procc0(p0), .out_procc1(p1), .out_procc2(p2), .out_procc3(p3),
    .out_extra_procc0(e0), .out_extra_procc1(e1), .out_extra_procc2(e2), .out_extra_procc3(e3),
    .mc_ready_in(mc_ready_in), .mc_valid_out(mc_valid_out),
    .mc_data_out_lo(lo), .mc_data_out_hi(hi),
    .busy(busy), .burst_done(burst_done), .overflow(overflow), .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int n);
    data_size = CW'(n);
    start = 1;
    step();
    start = 0;
  endtask

  task automatic send(input int i, input bit acc);
    {p0, p1, p2, p3} = {tbl[i].p0, tbl[i].p1, tbl[i].p2, tbl[i].p3};
    {e0, e1, e2, e3} = {tbl[i].e0, tbl[i].e1, tbl[i].e2, tbl[i].e3};
    result_valid = 1;
    if (acc) exp_q.push_back({tbl[i].hi, tbl[i].lo});
    step();
    result_valid = 0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      step();
      if (burst_done) seen = 1;
    end
    chk({name, "_done_seen"}, seen, 1);
    step();
    chk({name, "_done_pulse"}, burst_done, 0);
    chk({name, "_idle"}, busy, 0);
    chk({name, "_q_drained"}, exp_q.size(), 0);
  endtask

  // every handshake is settled by the negedge before the edge that pops it
  always @(negedge clk)
    if (reset && mc_valid_out && mc_ready_in) begin
      logic [255:0] e;
      pops++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %0h expected no word", {hi, lo});
      end else begin
        e = exp_q.pop_front();
        chk("pop_data", {hi, lo}, e);
      end
    end

  initial begin
    int p;
    tbl[0] = '{32'h66666666, 32'h55555555, 32'h22222222, 32'h11111111,
               32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111,
               128'h11111111_22222222_55555555_66666666, 128'h11111111_22222222_33333333_44444444};
    tbl[1] = '{32'ha0a0a0a0, 32'hb1b1b1b1, 32'hc2c2c2c2, 32'hd3d3d3d3,
               32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210,
               128'hd3d3d3d3_c2c2c2c2_b1b1b1b1_a0a0a0a0, 128'h76543210_fedcba98_89abcdef_01234567};
    tbl[2] = '{32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004,
               32'h80000000, 32'h40000000, 32'h20000000, 32'h10000000,
               128'h00000004_00000003_00000002_00000001, 128'h10000000_20000000_40000000_80000000};
    tbl[3] = '{32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff,
               32'h0, 32'h0, 32'h0, 32'h0,
               {128{1'b1}}, 128'h0};
    tbl[4] = '{32'hdeadbeef, 32'hcafef00d, 32'h12345678, 32'h9abcdef0,
               32'haaaaaaaa, 32'h55555555, 32'h0f0f0f0f, 32'hf0f0f0f0,
               128'h9abcdef0_12345678_cafef00d_deadbeef, 128'hf0f0f0f0_0f0f0f0f_55555555_aaaaaaaa};
    tbl[5] = '{32'h13579bdf, 32'h2468ace0, 32'h00ff00ff, 32'hff00ff00,
               32'h11223344, 32'h55667788, 32'h99aabbcc, 32'hddeeff00,
               128'hff00ff00_00ff00ff_2468ace0_13579bdf, 128'hddeeff00_99aabbcc_55667788_11223344};

    #1 reset = 0;
    step();
    chk("rst_valid", mc_valid_out, 0);
    chk("rst_data", {hi, lo}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", burst_done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_fill", fill_level, 0);
    reset = 1;
    step();

    send(0, 0);
    chk("idle_rv_fill", fill_level, 0);
    chk("idle_rv_valid", mc_valid_out, 0);

    go(0);
    chk("zero_done", burst_done, 1);
    chk("zero_busy", busy, 1);
    chk("zero_valid", mc_valid_out, 0);
    step();
    chk("zero_done_clear", burst_done, 0);
    chk("zero_idle", busy, 0);

    mc_ready_in = 1;
    go(2);
    send(0, 1);
    chk("basic_latency", mc_valid_out, 1);
    send(0, 1);
    wait_done("basic", 8);

    mc_ready_in = 0;
    go(3);
    send(2, 1);
    send(3, 1);
    send(4, 1);
    chk("bp_fill", fill_level, 3);
    chk("bp_head", {hi, lo}, {tbl[2].hi, tbl[2].lo});
    step();
    step();
    chk("bp_hold", {hi, lo}, {tbl[2].hi, tbl[2].lo});
    chk("bp_hold_valid", mc_valid_out, 1);
    mc_ready_in = 1;
    wait_done("bp", 10);

    mc_ready_in = 0;
    go(6);
    for (int i = 0; i < 6; i++) send(i, i < 4);
    chk("ovf_fill", fill_level, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drain_busy", busy, 1);
    chk("ovf_not_done", burst_done, 0);
    p = pops;
    mc_ready_in = 1;
    wait_done("ovf", 10);
    chk("ovf_word_count", pops - p, 4);
    chk("ovf_sticky", overflow, 1);

    mc_ready_in = 0;
    go(5);
    chk("ovf_cleared", overflow, 0);
    for (int i = 0; i < 4; i++) send(i, 1);
    chk("full_fill", fill_level, 4);
    mc_ready_in = 1;
    send(5, 1);
    chk("pushpop_fill", fill_level, 4);
    chk("pushpop_ovf", overflow, 0);
    wait_done("pushpop", 10);

    go(2);
    send(1, 1);
    go(5);
    send(2, 1);
    wait_done("restart_ignored", 4);

    mc_ready_in = 0;
    go(4);
    send(0, 1);
    send(1, 1);
    chk("midrst_fill", fill_level, 2);
    #2 reset = 0;
    #1;
    chk("midrst_valid", mc_valid_out, 0);
    chk("midrst_data", {hi, lo}, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_fill0", fill_level, 0);
    exp_q.delete();
    step();
    reset = 1;
    step();
    mc_ready_in = 1;
    go(2);
    send(3, 1);
    send(5, 1);
    wait_done("after_rst", 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
